// File: rtl/antilog_converter.sv
// antilog_converter: log-domain to linear converter (descale, split, Mitchell shift), 3-stage valid/ready pipeline
module antilog_converter #(
    parameter int DATA_W   = 32,
    parameter int INT_W    = 6,
    parameter int FRAC_W   = 16,
    parameter int SCALE_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INT_W+FRAC_W-1:0] in_log,
    input  logic                    in_zero,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_sat
);
    localparam int LW = INT_W + FRAC_W;

    logic              load1, load2, load3;
    logic              v1_q, v1_d, z1_q, z1_d;
    logic [LW-1:0]     y1_q, y1_d;
    logic              v2_q, v2_d, z2_q, z2_d, sat2_q, sat2_d;
    logic [INT_W-1:0]  w2_q, w2_d;
    logic [FRAC_W:0]   m2_q, m2_d;
    logic              v3_q, v3_d, sat3_q, sat3_d;
    logic [DATA_W-1:0] d3_q, d3_d;

    // A stage loads when empty or when its contents move on this cycle
    always_comb begin
        load3 = !v3_q || out_ready;
        load2 = !v2_q || load3;
        load1 = !v1_q || load2;
    end

    assign in_ready  = load1;
    assign out_valid = v3_q;
    assign out_data  = d3_q;
    assign out_sat   = sat3_q;

    // S1: remove the 1.0111b scale by multiplying with 0.1011b (truncating shifts)
    always_comb begin
        v1_d = v1_q;
        y1_d = y1_q;
        z1_d = z1_q;
        if (load1) begin
            v1_d = in_valid;
            y1_d = (SCALE_EN != 0) ? (in_log >> 1) + (in_log >> 3) + (in_log >> 4) : in_log;
            z1_d = in_zero;
        end
    end

    // S2: split into exponent and mantissa 1.f, flag exponents that overflow the output
    always_comb begin
        v2_d   = v2_q;
        w2_d   = w2_q;
        m2_d   = m2_q;
        sat2_d = sat2_q;
        z2_d   = z2_q;
        if (load2) begin
            v2_d   = v1_q;
            w2_d   = y1_q[LW-1:FRAC_W];
            m2_d   = {1'b1, y1_q[FRAC_W-1:0]};
            sat2_d = (int'(y1_q[LW-1:FRAC_W]) >= DATA_W) && !z1_q;
            z2_d   = z1_q;
        end
    end

    // S3: (1.f) << w as one left shift followed by dropping the fraction bits; zero beats saturation
    always_comb begin
        v3_d   = v3_q;
        d3_d   = d3_q;
        sat3_d = sat3_q;
        if (load3) begin
            v3_d   = v2_q;
            d3_d   = z2_q ? '0 : sat2_q ? '1 : DATA_W'(({{DATA_W{1'b0}}, m2_q} << w2_q) >> FRAC_W);
            sat3_d = sat2_q && !z2_q;
        end
    end

    // Pipeline registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q   <= 1'b0;
            y1_q   <= '0;
            z1_q   <= 1'b0;
            v2_q   <= 1'b0;
            w2_q   <= '0;
            m2_q   <= '0;
            sat2_q <= 1'b0;
            z2_q   <= 1'b0;
            v3_q   <= 1'b0;
            d3_q   <= '0;
            sat3_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            y1_q   <= y1_d;
            z1_q   <= z1_d;
            v2_q   <= v2_d;
            w2_q   <= w2_d;
            m2_q   <= m2_d;
            sat2_q <= sat2_d;
            z2_q   <= z2_d;
            v3_q   <= v3_d;
            d3_q   <= d3_d;
            sat3_q <= sat3_d;
        end
    end
endmodule

// File: tb/tb_antilog_converter.sv
// tb_antilog_converter: random and directed checks of both scaling modes against an arithmetic model
module tb_antilog_converter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [21:0] in_log = '0;
    logic        in_zero = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready0, in_ready1, out_valid0, out_valid1, out_sat0, out_sat1;
    logic [31:0] out_data0, out_data1;

    int n_checks = 0;
    int n_fail = 0;
    logic [32:0] exp0[$], exp1[$], got0[$], got1[$];

    always #5 clk = ~clk;

    antilog_converter #(.DATA_W(32), .INT_W(6), .FRAC_W(16), .SCALE_EN(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_log(in_log),
        .in_zero(in_zero), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_sat(out_sat0));

    antilog_converter #(.DATA_W(32), .INT_W(6), .FRAC_W(16), .SCALE_EN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_log(in_log),
        .in_zero(in_zero), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_sat(out_sat1));

    // Reference: value = 2^(y) with y = w.f, linearised as (1 + f/2^16) * 2^w, fraction dropped
    function automatic logic [32:0] model(input logic [21:0] x, input logic z, input bit sc);
        longint y, w, f, v;
        y = sc ? (longint'(x) / 2 + longint'(x) / 8 + longint'(x) / 16) : longint'(x);
        w = y / 65536;
        f = y % 65536;
        if (z) return 33'd0;
        if (w >= 32) return {1'b1, 32'hFFFF_FFFF};
        v = ((65536 + f) * (longint'(1) << w)) / 65536;
        return {1'b0, v[31:0]};
    endfunction

    task automatic clear_queues();
        exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
    endtask

    task automatic cycle(input logic v, input logic [21:0] x, input logic z, input logic ordy, output logic acc);
        in_valid = v; in_log = x; in_zero = z; out_ready = ordy;
        #1;
        acc = v && in_ready0;
        if (acc) begin
            exp0.push_back(model(x, z, 1'b0));
            exp1.push_back(model(x, z, 1'b1));
        end
        if (out_valid0 && ordy) got0.push_back({out_sat0, out_data0});
        if (out_valid1 && ordy) got1.push_back({out_sat1, out_data1});
        @(posedge clk);
        #1;
    endtask

    task automatic drain(output logic timeout);
        logic a;
        int k = 0;
        while ((got0.size() < exp0.size() || got1.size() < exp1.size()) && k < 60) begin
            cycle(1'b0, '0, 1'b0, 1'b1, a);
            k++;
        end
        timeout = (k >= 60);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid0: got %b expected 0", out_valid0); end
        n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid1: got %b expected 0", out_valid1); end
        n_checks++; if (out_data0 !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data0); end
        n_checks++; if (out_sat0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat: got %b expected 0", out_sat0); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (in_ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready0); end
    endtask

    task automatic test_latency(input logic [21:0] x, input logic [32:0] want, input string name);
        logic a, to;
        int n;
        clear_queues();
        cycle(1'b1, x, 1'b0, 1'b1, a);
        n = 1;
        while (!out_valid0 && n < 10) begin
            cycle(1'b0, '0, 1'b0, 1'b1, a);
            n++;
        end
        drain(to);
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL %s_latency: got %0d cycles expected 3", name, n); end
        n_checks++; if (to !== 1'b0 || got0.size() != 1 || got0[0] !== want) begin
            n_fail++; $display("FAIL %s_value: got %h (count %0d) expected %h", name, got0.size() > 0 ? got0[0] : 33'h0, got0.size(), want);
        end
    endtask

    task automatic test_directed();
        logic [22:0] vec[8] = '{{1'b0, 6'd4, 16'h8000}, {1'b0, 6'd2, 16'h4000}, {1'b0, 6'd1, 16'h8000},
                                {1'b0, 6'd0, 16'h0000}, {1'b0, 6'd31, 16'hFFFF}, {1'b0, 6'd32, 16'h0000},
                                {1'b1, 6'd32, 16'h0000}, {1'b0, 6'd8, 16'h0000}};
        logic [32:0] want0[8] = '{{1'b0, 32'd24}, {1'b0, 32'd5}, {1'b0, 32'd3}, {1'b0, 32'd1},
                                  {1'b0, 32'hFFFF8000}, {1'b1, 32'hFFFFFFFF}, {1'b0, 32'd0}, {1'b0, 32'd256}};
        logic a, to;
        int acc_n = 0;
        clear_queues();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, vec[i][21:0], vec[i][22], 1'b1, a);
            if (a) acc_n++;
        end
        drain(to);
        n_checks++; if (acc_n !== 8) begin n_fail++; $display("FAIL directed_throughput: got %0d accepts expected 8", acc_n); end
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL directed_drain: got timeout expected all outputs"); end
        for (int i = 0; i < 8 && i < got0.size(); i++) begin
            n_checks++; if (got0[i] !== want0[i]) begin n_fail++; $display("FAIL directed_noscale[%0d]: got %h expected %h", i, got0[i], want0[i]); end
        end
        for (int i = 0; i < 8 && i < got1.size(); i++) begin
            n_checks++; if (got1[i] !== exp1[i]) begin n_fail++; $display("FAIL directed_scale[%0d]: got %h expected %h", i, got1[i], exp1[i]); end
        end
        n_checks++; if (got1.size() != 8 || got1[7] !== {1'b0, 32'd48}) begin
            n_fail++; $display("FAIL directed_scale_8: got %h expected 48", got1.size() == 8 ? got1[7] : 33'h0);
        end
    endtask

    task automatic test_backpressure();
        logic [21:0] word[4] = '{{6'd0, 16'h0}, {6'd1, 16'h0}, {6'd2, 16'h0}, {6'd3, 16'h0}};
        logic [32:0] want[4] = '{{1'b0, 32'd1}, {1'b0, 32'd2}, {1'b0, 32'd4}, {1'b0, 32'd8}};
        logic a, to;
        int idx = 0;
        clear_queues();
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, word[idx], 1'b0, 1'b0, a);
            if (a) idx++;
            if (c >= 2) begin
                n_checks++; if (out_valid0 !== 1'b1 || out_data0 !== 32'd1) begin
                    n_fail++; $display("FAIL bp_hold[%0d]: got valid %b data %h expected valid 1 data 1", c, out_valid0, out_data0);
                end
            end
        end
        n_checks++; if (idx !== 3) begin n_fail++; $display("FAIL bp_capacity: got %0d accepts expected 3", idx); end
        n_checks++; if (in_ready0 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready0); end
        cycle(1'b1, word[idx], 1'b0, 1'b1, a);
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL bp_full_passthrough: got accept %b expected 1", a); end
        drain(to);
        n_checks++; if (to !== 1'b0 || got0.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d words expected 4", got0.size()); end
        for (int i = 0; i < 4 && i < got0.size(); i++) begin
            n_checks++; if (got0[i] !== want[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got0[i], want[i]); end
        end
    endtask

    task automatic test_random();
        logic a, to;
        int w;
        clear_queues();
        for (int c = 0; c < 400; c++) begin
            w = $urandom_range(0, 40);
            cycle(($urandom % 4) != 0, {w[5:0], 16'($urandom)}, ($urandom % 8) == 0, ($urandom % 4) != 0, a);
        end
        drain(to);
        n_checks++; if (to !== 1'b0 || got0.size() != exp0.size() || got1.size() != exp1.size()) begin
            n_fail++; $display("FAIL random_count: got %0d/%0d words expected %0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size());
        end
        for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
            n_checks++; if (got0[i] !== exp0[i]) begin n_fail++; $display("FAIL random_noscale[%0d]: got %h expected %h", i, got0[i], exp0[i]); end
        end
        for (int i = 0; i < got1.size() && i < exp1.size(); i++) begin
            n_checks++; if (got1[i] !== exp1[i]) begin n_fail++; $display("FAIL random_scale[%0d]: got %h expected %h", i, got1[i], exp1[i]); end
        end
    endtask

    task automatic test_reset_midstream();
        logic a;
        clear_queues();
        cycle(1'b1, {6'd3, 16'h0}, 1'b0, 1'b0, a);
        cycle(1'b1, {6'd5, 16'h0}, 1'b0, 1'b0, a);
        cycle(1'b0, '0, 1'b0, 1'b0, a);
        n_checks++; if (out_valid0 !== 1'b1) begin n_fail++; $display("FAIL midrst_before: got valid %b expected 1", out_valid0); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
            n_fail++; $display("FAIL midrst_valid: got %b/%b expected 0/0", out_valid0, out_valid1);
        end
        n_checks++; if (out_data0 !== 32'd0) begin n_fail++; $display("FAIL midrst_data: got %h expected 0", out_data0); end
        @(posedge clk);
        #1 rst = 1'b1;
        clear_queues();
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b1, a);
        n_checks++; if (got0.size() != 0 || got1.size() != 0) begin
            n_fail++; $display("FAIL midrst_stale: got %0d/%0d words expected 0", got0.size(), got1.size());
        end
        test_latency({6'd10, 16'h4000}, {1'b0, 32'd1280}, "midrst_next");
    endtask

    initial begin
        test_reset();
        test_latency({6'd4, 16'h8000}, {1'b0, 32'd24}, "basic");
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
